// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter among byte producers
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_valid_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_ready_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic [IDX_W-1:0]      owner_next;
    logic                  release_now;

    // First valid requester scanning from ptr upward, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                own_valid = req_valid_i[k];
                own_last  = req_last_i[k];
                own_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_next = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);

    assign release_now = (state_q == LOCKED) && own_valid && tx_ready_i
                         && (own_last || (count_q == LAST_CNT));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOCKED;
                    owner_d = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    count_d = '0;
                end
            end
            LOCKED: begin
                // Pointer moves past the owner so it cannot win again ahead of waiters.
                if (release_now) begin
                    state_d = IDLE;
                    ptr_d   = owner_next;
                    grant_d = '0;
                    count_d = '0;
                end else if (own_valid && tx_ready_i) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            grant_q <= grant_d;
        end
    end

    // Outputs are forced low while reset is asserted, even before the next edge.
    always_comb begin
        req_ready_o = '0;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        if (rst && (state_q == LOCKED)) begin
            tx_valid_o  = own_valid;
            tx_data_o   = own_valid ? own_data : '0;
            req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
        end
    end

    assign grant_o = rst ? grant_q : '0;
    assign busy_o  = rst && (state_q == LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             tx_valid;
    logic [DW-1:0]    tx_data;
    logic             tx_ready;
    logic [NR-1:0]    grant;
    logic             busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
        .grant_o(grant), .busy_o(busy)
    );

    typedef struct {
        int          phase;
        int          req;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  grant;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] grant;
    } exp_t;

    vec_t       vecs[$];
    exp_t       exp_q[$];
    logic [8:0] src_q [NR][$];
    bit         rdy_q[$];
    logic [3:0] gtrace[$];
    int         checks = 0;
    int         failures = 0;
    int         stall_cnt = 0;
    logic       stalled = 1'b0;
    logic [7:0] stall_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic add(input int p, input int r, input logic [7:0] d, input logic l, input logic [3:0] g);
        vec_t v;
        v.phase = p; v.req = r; v.data = d; v.last = l; v.grant = g;
        vecs.push_back(v);
    endtask

    task automatic drive();
        logic [8:0] head;
        for (int k = 0; k < NR; k++) begin
            if (src_q[k].size() > 0) begin
                head = src_q[k][0];
                req_valid[k]         = 1'b1;
                req_last[k]          = head[8];
                req_data[k*DW +: DW] = head[7:0];
            end else begin
                req_valid[k]         = 1'b0;
                req_last[k]          = 1'b0;
                req_data[k*DW +: DW] = '0;
            end
        end
        tx_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    endtask

    task automatic load_phase(input int p);
        exp_t e;
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                src_q[vecs[i].req].push_back({vecs[i].last, vecs[i].data});
                e.data  = vecs[i].data;
                e.grant = vecs[i].grant;
                exp_q.push_back(e);
            end
        end
        drive();
    endtask

    task automatic clear_all();
        for (int k = 0; k < NR; k++) src_q[k].delete();
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic cycle();
        logic [NR-1:0] took;
        exp_t e;
        @(negedge clk);
        gtrace.push_back(grant);
        chk("ready_map", req_ready, grant & {NR{tx_ready}});
        chk("valid_map", tx_valid, |(grant & req_valid));
        chk("busy_map", busy, |grant);
        chk("grant_onehot", $onehot0(grant), 1);
        if (!tx_valid) chk("data_idle_zero", tx_data, 0);
        if (stalled) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, stall_data);
        end
        stalled    = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (stalled) stall_cnt++;
        took = req_valid & req_ready;
        if (tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra: got byte %h grant %b, required no transfer", tx_data, grant);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.data || grant !== e.grant) begin
                    failures++;
                    $display("FAIL sb_byte: got data %h grant %b, required data %h grant %b",
                             tx_data, grant, e.data, e.grant);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++)
            if (took[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d bytes outstanding after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic reset_hold(input int ncyc);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_now_tx_valid", tx_valid, 0);
        chk("rst_now_tx_data", tx_data, 0);
        chk("rst_now_req_ready", req_ready, 0);
        chk("rst_now_grant", grant, 0);
        chk("rst_now_busy", busy, 0);
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        chk("rst_after_grant", grant, 0);
        chk("rst_after_busy", busy, 0);
        chk("rst_after_tx_valid", tx_valid, 0);
        chk("rst_after_req_ready", req_ready, 0);
        stalled = 1'b0;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_tr [16];
        rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;

        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NR; k++)
                add(0, k, 8'((r + 1) * 16 + k), 1'b1, 4'(1 << k));
        add(1, 2, 8'h41, 1'b0, 4'b0100);
        add(1, 2, 8'h42, 1'b0, 4'b0100);
        add(1, 2, 8'h43, 1'b1, 4'b0100);
        add(2, 3, 8'h30, 1'b1, 4'b1000);
        add(2, 0, 8'h31, 1'b1, 4'b0001);
        add(3, 0, 8'hA5, 1'b0, 4'b0001);
        add(3, 0, 8'h5A, 1'b1, 4'b0001);
        for (int i = 0; i < 4; i++) add(4, 1, 8'(i), 1'b0, 4'b0010);
        add(4, 3, 8'h33, 1'b1, 4'b1000);
        for (int i = 4; i < 10; i++) add(4, 1, 8'(i), 1'b0, 4'b0010);
        add(5, 2, 8'h60, 1'b0, 4'b0100);
        add(5, 2, 8'h61, 1'b0, 4'b0100);
        add(6, 0, 8'h70, 1'b1, 4'b0001);
        add(6, 2, 8'h72, 1'b1, 4'b0100);

        exp_tr = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8,
                   4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8};

        // Reset with everyone valid, then round-robin of single-byte packets.
        load_phase(0);
        reset_hold(2);
        reset_release();
        gtrace.delete();
        drain(64);
        chk("trace_len", gtrace.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < gtrace.size()) chk($sformatf("trace_%0d", i), gtrace[i], exp_tr[i]);

        // Single three-byte packet, then pointer lands on requester 3.
        load_phase(1);
        drain(32);
        cycle();
        chk("release_grant", gtrace[$], 0);
        chk("release_busy", busy, 0);
        load_phase(2);
        drain(32);

        // Backpressure during a two-byte packet.
        stall_cnt = 0;
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        load_phase(3);
        drain(32);
        chk("bp_stall_cycles", stall_cnt, 2);

        // Burst limit, then owner idles mid-packet and keeps the grant.
        load_phase(4);
        drain(64);
        src_q[3].push_back({1'b1, 8'h34});
        drive();
        repeat (4) begin
            cycle();
            chk("hold_grant", gtrace[$], 4'b0010);
        end
        chk("hold_busy", busy, 1);

        clear_all();
        drive();
        reset_hold(1);
        reset_release();

        // Reset mid-packet, then pointer restarts at 0.
        load_phase(5);
        src_q[2].push_back({1'b0, 8'h62});
        src_q[2].push_back({1'b0, 8'h63});
        src_q[2].push_back({1'b1, 8'h64});
        drive();
        drain(32);
        reset_hold(1);
        clear_all();
        load_phase(6);
        reset_release();
        drain(32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers (echo path, status reporter, debug console, ...). Grants the TX to one requester for a whole packet, bounded by req_last_i or MAX_BURST bytes, then re-arbitrates. It sits between the producers and the uart_tx serializer's valid/ready input.

Parameters:
DATA_WIDTH, 8, bits per UART character.
NUM_REQ, 4, number of requesters (2..8).
MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-low reset.
req_valid_i  input  NUM_REQ  per-requester byte valid.
req_data_i  input  NUM_REQ*DATA_WIDTH  requester k byte in bits [k*DATA_WIDTH +: DATA_WIDTH].
req_last_i  input  NUM_REQ  marks requester's final byte of packet (qualified by valid).
req_ready_o  output  NUM_REQ  per-requester accept.
tx_valid_o  output  1  byte valid to uart_tx.
tx_data_o  output  DATA_WIDTH  byte to uart_tx.
tx_ready_i  input  1  uart_tx can accept.
grant_o  output  NUM_REQ  one-hot current owner, all zero when idle.
busy_o  output  1  high while a grant is held.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, grant_o=0, busy_o=0, rr pointer=0, burst count=0. All outputs 0 during reset: tx_valid_o=0, tx_data_o=0, req_ready_o=0. Reset mid-packet drops the grant immediately. The partially sent packet is not resumed.
- FSM states: IDLE and LOCKED.
- IDLE: if any req_valid_i is high, select the first set index scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: state=LOCKED, grant_o=onehot(winner), busy_o=1, count=0.
  - No byte transfers in IDLE: tx_valid_o=0, req_ready_o=0.
  - Arbitration latency is exactly 1 cycle from valid to grant.
- LOCKED with owner g (combinational pass-through):
  - tx_valid_o=req_valid_i[g]; tx_data_o=req_data_i[g]; req_ready_o[g]=tx_ready_i.
  - Every other req_ready_o bit=0. tx_data_o=0 when tx_valid_o=0.
  - A transfer occurs when tx_valid_o && tx_ready_i. Each transfer increments count.
- Release: a transfer with req_last_i[g]=1, or with count+1==MAX_BURST, returns to IDLE next cycle.
  - On release: ptr=(g+1) mod NUM_REQ, grant_o=0, busy_o=0, count=0.
  - The owner cannot be regranted before the others that are waiting have been served.
- Owner deasserting valid mid-packet: grant is held indefinitely, with no timeout. Other requesters are stalled.
- req_last_i without req_valid_i, or on a non-owner, is ignored.
- Requester inputs must stay stable while valid && !ready. This is the producer's obligation. The arbiter does not check it.
- Back-to-back packets cost one idle cycle between grants: the arbitration bubble.
- count width is clog2(MAX_BURST+1). count never exceeds MAX_BURST-1 in LOCKED.
- NUM_REQ==1 degenerates to pass-through with the 1-cycle IDLE bubble per packet.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with all req_valid_i=1 -> all outputs 0. After release, grant_o=4'b0001 exactly 1 cycle later.
2. Single packet: req 2 sends 0x41,0x42,0x43 with last on 0x43, tx_ready_i=1 -> tx_data_o sequence 41,42,43. grant_o=4'b0100 throughout, then 0. Next ptr=3.
3. Round-robin fairness: all four requesters continuously valid with 1-byte packets (last=1) -> grant order 0,1,2,3,0,..., with one idle cycle between each grant.
4. Burst limit with MAX_BURST=4: req 1 streams 10 bytes 0x00..0x09 with no last, and req 3 valid -> req 1 sends 00..03, then req 3 is granted, then req 1 resumes at 0x04.
5. Backpressure: tx_ready_i toggles 1,0,0,1 during req 0 packet 0xA5,0x5A -> each byte appears exactly once and is held stable while ready is 0. req_ready_o[0] mirrors tx_ready_i.
6. Reset mid-packet: assert rst=0 after 2 of 5 bytes from req 2 -> grant_o=0 the next cycle. After reset, req 0 and req 2 both valid -> req 0 is granted first (ptr=0).
